// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester/memory bundle for the two-port data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int AW = 32
);
   logic          p0_req;
   logic          p0_we;
   logic          p0_lock;
   logic [AW-1:0] p0_addr;
   logic [31:0]   p0_wdata;
   logic          p0_gnt;
   logic          p0_rvalid;
   logic [31:0]   p0_rdata;

   logic          p1_req;
   logic          p1_we;
   logic          p1_lock;
   logic [AW-1:0] p1_addr;
   logic [31:0]   p1_wdata;
   logic          p1_gnt;
   logic          p1_rvalid;
   logic [31:0]   p1_rdata;

   logic          mem_wr;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          err;

   // Requesters and the memory array sit on the master side.
   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_wr, mem_rd, mem_addr, mem_wdata,
      output mem_rdata,
      input  err
   );

   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_wr, mem_rd, mem_addr, mem_wdata,
      input  mem_rdata,
      output err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port round-robin data memory arbiter with lock ownership.
//            Optional address range check enabled by DMEM_ARB_RANGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  wire logic      clk,
   input  wire logic      reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   if (DEPTH < 1) begin : g_depth_check
      $error("dmem_arbiter: DEPTH must be at least 1");
   end

   state_t        r_state;
   state_t        w_state_next;
   logic          r_ptr;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_gnt_any;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [31:0]   w_sel_wdata;
   logic          w_oob;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [31:0]   r_rdata0;
   logic [31:0]   r_rdata1;
   logic          r_err;

   // Grant decode; reset blanks grants so nothing reaches memory while held.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!reset) begin
         unique case (r_state)
            IDLE: begin
               if (bus.p0_req && bus.p1_req) begin
                  w_gnt0 = ~r_ptr;
                  w_gnt1 = r_ptr;
               end else begin
                  w_gnt0 = bus.p0_req;
                  w_gnt1 = bus.p1_req;
               end
            end
            OWN0:    w_gnt0 = bus.p0_req;
            OWN1:    w_gnt1 = bus.p1_req;
            default: ;
         endcase
      end
   end

   assign w_gnt_any = w_gnt0 | w_gnt1;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_gnt0 && bus.p0_lock) begin
               w_state_next = OWN0;
            end else if (w_gnt1 && bus.p1_lock) begin
               w_state_next = OWN1;
            end
         end
         OWN0: begin
            if (w_gnt0) begin
               w_state_next = bus.p0_lock ? OWN0 : IDLE;
            end else if (!bus.p0_lock) begin
               w_state_next = IDLE;
            end
         end
         OWN1: begin
            if (w_gnt1) begin
               w_state_next = bus.p1_lock ? OWN1 : IDLE;
            end else if (!bus.p1_lock) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      if (w_gnt0) begin
         w_sel_we    = bus.p0_we;
         w_sel_addr  = bus.p0_addr;
         w_sel_wdata = bus.p0_wdata;
      end else if (w_gnt1) begin
         w_sel_we    = bus.p1_we;
         w_sel_addr  = bus.p1_addr;
         w_sel_wdata = bus.p1_wdata;
      end
   end

`ifdef DMEM_ARB_RANGE_EN
   localparam logic [AW-1:0] c_depth = AW'(DEPTH);
   assign w_oob = w_gnt_any && (w_sel_addr >= c_depth);
`else
   assign w_oob = 1'b0;
`endif

   assign bus.mem_wr    = w_gnt_any &  w_sel_we & ~w_oob;
   assign bus.mem_rd    = w_gnt_any & ~w_sel_we & ~w_oob;
   assign bus.mem_addr  = w_sel_addr;
   assign bus.mem_wdata = w_sel_wdata;

   // The pointer names the port that wins the next IDLE tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= 1'b0;
      end else if (w_gnt_any) begin
         r_ptr <= w_gnt0;
      end
   end

   // Out-of-range reads still complete, returning zero instead of memory data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 & ~bus.p0_we;
         r_rvalid1 <= w_gnt1 & ~bus.p1_we;
         r_err     <= w_oob;
         if (w_gnt0 && !bus.p0_we) begin
            r_rdata0 <= w_oob ? 32'h0 : bus.mem_rdata;
         end
         if (w_gnt1 && !bus.p1_we) begin
            r_rdata1 <= w_oob ? 32'h0 : bus.mem_rdata;
         end
      end
   end

   assign bus.p0_gnt    = w_gnt0;
   assign bus.p1_gnt    = w_gnt1;
   assign bus.p0_rvalid = r_rvalid0;
   assign bus.p1_rvalid = r_rvalid1;
   assign bus.p0_rdata  = r_rdata0;
   assign bus.p1_rdata  = r_rdata1;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and random checks of dmem_arbiter against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
   localparam int AW    = 32;
   localparam int DEPTH = 64;
`ifdef DMEM_ARB_RANGE_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW)) bus ();
   dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic          req   [2];
   logic          we    [2];
   logic          lock  [2];
   logic [AW-1:0] addr  [2];
   logic [31:0]   wdata [2];

   assign bus.p0_req   = req[0];
   assign bus.p0_we    = we[0];
   assign bus.p0_lock  = lock[0];
   assign bus.p0_addr  = addr[0];
   assign bus.p0_wdata = wdata[0];
   assign bus.p1_req   = req[1];
   assign bus.p1_we    = we[1];
   assign bus.p1_lock  = lock[1];
   assign bus.p1_addr  = addr[1];
   assign bus.p1_wdata = wdata[1];

   // Memory array attached to the arbiter; junk data when no read is enabled.
   logic [31:0] env_mem [DEPTH] = '{default: 32'h0};
   always @(posedge clk) begin
      if (bus.mem_wr) env_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = bus.mem_rd ? env_mem[bus.mem_addr[5:0]] : 32'hA5A5_5A5A;

   // Reference model: owner (-1 none), preferred port on ties, expected registers.
   int          m_owner;
   int          m_pref;
   logic [31:0] ref_mem [DEPTH];
   logic        m_rv [2];
   logic [31:0] m_rd [2];
   logic        m_err;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_pref  = 0;
      m_err   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_rv[i] = 1'b0;
         m_rd[i] = 32'h0;
      end
   endtask

   task automatic set_port(input int p, input bit r, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [31:0] d);
      req[p]   = r;
      we[p]    = w;
      lock[p]  = l;
      addr[p]  = a;
      wdata[p] = d;
   endtask

   task automatic idle_ports();
      set_port(0, 0, 0, 0, '0, '0);
      set_port(1, 0, 0, 0, '0, '0);
   endtask

   function automatic logic [159:0] all_outputs();
      return {bus.p0_gnt, bus.p1_gnt, bus.mem_wr, bus.mem_rd, bus.p0_rvalid, bus.p1_rvalid,
              bus.err, bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_wdata};
   endfunction

   // One clock of traffic: check combinational grant/memory outputs, clock,
   // then check the registered read/err outputs against the model.
   task automatic step(input string tag);
      int          g;
      int          gi;
      int          idx;
      bit          oob;
      logic [67:0] exp_c;
      logic [66:0] exp_r;
      #1;
      if (m_owner < 0) begin
         if (req[0] && req[1]) g = m_pref;
         else if (req[0])      g = 0;
         else if (req[1])      g = 1;
         else                  g = -1;
      end else begin
         g = req[m_owner] ? m_owner : -1;
      end
      gi  = (g < 0) ? 0 : g;
      oob = (g >= 0) && RANGE_EN && (addr[gi] >= AW'(DEPTH));
      exp_c = {g == 0, g == 1,
               (g >= 0) && we[gi] && !oob,
               (g >= 0) && !we[gi] && !oob,
               (g >= 0) ? addr[gi] : AW'(0),
               (g >= 0) ? wdata[gi] : 32'h0};
      check({tag, "/comb"}, 160'({bus.p0_gnt, bus.p1_gnt, bus.mem_wr, bus.mem_rd,
                                   bus.mem_addr, bus.mem_wdata}), 160'(exp_c));
      @(posedge clk);
      #1;
      m_rv[0] = 1'b0;
      m_rv[1] = 1'b0;
      m_err   = oob;
      if (g >= 0) begin
         idx = int'(addr[gi] % DEPTH);
         if (!we[gi]) begin
            m_rv[gi] = 1'b1;
            m_rd[gi] = oob ? 32'h0 : ref_mem[idx];
         end else if (!oob) begin
            ref_mem[idx] = wdata[gi];
         end
         m_pref  = 1 - g;
         m_owner = lock[gi] ? g : -1;
      end else if (m_owner >= 0 && !req[m_owner] && !lock[m_owner]) begin
         m_owner = -1;
      end
      exp_r = {m_rv[0], m_rv[1], m_err, m_rd[0], m_rd[1]};
      check({tag, "/reg"}, 160'({bus.p0_rvalid, bus.p1_rvalid, bus.err,
                                  bus.p0_rdata, bus.p1_rdata}), 160'(exp_r));
   endtask

   task automatic do_reset(input string tag);
      idle_ports();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check(tag, all_outputs(), 160'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      model_reset();
      idle_ports();
      do_reset("reset_state");

      // Write then read back the same word from port 0.
      set_port(0, 1, 1, 0, AW'(5), 32'hDEAD_BEEF);
      step("p0_wr5");
      set_port(0, 1, 0, 0, AW'(5), 32'h0);
      step("p0_rd5");
      idle_ports();
      step("p0_idle");
      check("p0_rdata_hold", 160'(bus.p0_rdata), 160'(32'hDEAD_BEEF));

      // Both ports read continuously: alternating grants starting at port 0.
      do_reset("reset_rr");
      set_port(0, 1, 0, 0, AW'(5), 32'h0);
      set_port(1, 1, 0, 0, AW'(6), 32'h0);
      for (int i = 0; i < 4; i++) step($sformatf("rr_%0d", i));

      // Port 1 locks for three cycles while port 0 keeps asking.
      idle_ports();
      set_port(1, 1, 1, 1, AW'(5), 32'h0);
      step("lock_1");
      set_port(0, 1, 0, 0, AW'(6), 32'h0);
      step("lock_2");
      step("lock_3");
      set_port(1, 1, 0, 0, AW'(5), 32'h0);
      step("lock_release");
      set_port(1, 0, 0, 0, '0, '0);
      step("lock_p0_next");

      // Reset lands mid-cycle while port 1 owns the memory with a read pending.
      idle_ports();
      set_port(1, 1, 0, 1, AW'(5), 32'h0);
      step("own1_a");
      set_port(0, 1, 0, 0, AW'(6), 32'h0);
      step("own1_b");
      #1;
      reset = 1'b1;
      #1;
      check("rst_async", all_outputs(), 160'h0);
      @(posedge clk);
      #1;
      check("rst_hold", all_outputs(), 160'h0);
      idle_ports();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_release", all_outputs(), 160'h0);
      set_port(0, 1, 0, 0, AW'(5), 32'h0);
      set_port(1, 1, 0, 0, AW'(6), 32'h0);
      step("post_rst_tie");
      idle_ports();
      step("post_rst_idle");

      // Address at DEPTH: dropped with err when range checking is built in.
      set_port(0, 1, 1, 0, AW'(0), 32'h1234_5678);
      step("w0");
      set_port(0, 1, 1, 0, AW'(64), 32'h0000_0001);
      step("w64");
      set_port(0, 1, 0, 0, AW'(0), 32'h0);
      step("r0_after_w64");
      set_port(0, 1, 0, 0, AW'(64), 32'h0);
      step("r64");
      idle_ports();
      step("range_idle");

      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(60, 70))
                                            : AW'($urandom_range(0, 9));
            set_port(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, a, $urandom());
         end
         step($sformatf("rand_%0d", i));
      end

      idle_ports();
      step("final_idle");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
